dmem_wait: RTL and testbench

- Data-memory stage that sits directly downstream of the single-cycle MIPS datapath.
- Consumes the datapath's aluout (as the address), writedata and the memory-control strobes.
- Returns readdata to the datapath through a word-addressed RAM with a configurable wait-state latency.
- Raises stall so the top level can freeze PC/register writeback until the access completes.

---
 rtl/dmem_wait.sv | 98 +++++++++
 tb/tb_dmem_wait.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/dmem_wait.sv
// Word-addressed data memory with fixed wait-state latency.
// Stalls the datapath from request until the access completes.
module dmem_wait #(
  parameter int DEPTH_LOG2 = 6,
  parameter int LATENCY    = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        memread,
  input  logic        memwrite,
  input  logic [31:0] addr,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        stall,
  output logic        misalign
);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  state_t                state;
  logic [3:0]            cnt;
  logic [DEPTH_LOG2-1:0] idx;
  logic [1:0]            off;
  logic [31:0]           wdata;
  logic                  wr;
  logic                  req;
  logic                  commit;
  logic                  unused_hi;

  logic [31:0] mem [2**DEPTH_LOG2];

  assign req       = memread | memwrite;
  assign commit    = (state == BUSY) && (cnt == 4'd0);
  assign unused_hi = ^addr[31:DEPTH_LOG2+2];

  always_comb begin
    stall = 1'b0;
    unique case (state)
      IDLE:    stall = req;
      BUSY:    stall = 1'b1;
      default: stall = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= 4'd0;
      readdata <= 32'd0;
      misalign <= 1'b0;
      idx      <= '0;
      off      <= 2'd0;
      wdata    <= 32'd0;
      wr       <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          misalign <= 1'b0;
          if (req) begin
            state <= BUSY;
            idx   <= addr[DEPTH_LOG2+1:2];
            off   <= addr[1:0];
            wdata <= writedata;
            wr    <= memwrite;
            cnt   <= CNT_INIT;
          end
        end
        BUSY: begin
          if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end else begin
            state    <= DONE;
            misalign <= (off != 2'd0);
            if (!wr)
              readdata <= (off == 2'd0) ? mem[idx] : 32'd0;
          end
        end
        default: begin
          state    <= IDLE;
          misalign <= 1'b0;
        end
      endcase
    end
  end

  // RAM has no reset; a write lands only on the BUSY->DONE edge.
  always_ff @(posedge clk) begin
    if (!reset && commit && wr && off == 2'd0)
      mem[idx] <= wdata;
  end

endmodule

// File: tb/tb_dmem_wait.sv
// Bench for dmem_wait: directed table, reset abort, then
// random transactions against a word-array model.
module tb_dmem_wait;

  localparam int DL  = 6;
  localparam int LAT = 2;

  logic        clk;
  logic        reset;
  logic        memread;
  logic        memwrite;
  logic [31:0] addr;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        stall;
  logic        misalign;

  int vectors;
  int miscompares;

  dmem_wait #(.DEPTH_LOG2(DL), .LATENCY(LAT)) dut (
    .clk(clk),
    .reset(reset),
    .memread(memread),
    .memwrite(memwrite),
    .addr(addr),
    .writedata(writedata),
    .readdata(readdata),
    .stall(stall),
    .misalign(misalign)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] d;
    logic [31:0] rd;
    logic        mis;
  } vec_t;

  vec_t        tbl[13];
  logic [31:0] mem_m[2**DL];
  logic [31:0] rd_m;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // op: 0 read, 1 write, 2 both strobes
  task automatic access(input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] d, input logic [31:0] exp_rd,
                        input logic exp_mis);
    memread   = (op != 2'd1);
    memwrite  = (op != 2'd0);
    addr      = a;
    writedata = d;
    for (int i = 0; i <= LAT; i++) begin
      @(negedge clk);
      chk("stall_pending", 32'(stall), 32'd1);
      chk("misalign_pending", 32'(misalign), 32'd0);
      @(posedge clk);
      #1;
      if (i == 0) begin
        addr      = $urandom;
        writedata = $urandom;
        memread   = 1'($urandom_range(1));
        memwrite  = 1'($urandom_range(1));
      end
    end
    memread  = 1'b0;
    memwrite = 1'b0;
    @(negedge clk);
    chk("stall_done", 32'(stall), 32'd0);
    chk("readdata_done", readdata, exp_rd);
    chk("misalign_done", 32'(misalign), 32'(exp_mis));
    @(posedge clk);
    #1;
  endtask

  task automatic idle_gap();
    memread  = 1'b0;
    memwrite = 1'b0;
    @(negedge clk);
    chk("stall_idle", 32'(stall), 32'd0);
    chk("misalign_idle", 32'(misalign), 32'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] d;
    logic [31:0] er;
    logic        em;

    vectors     = 0;
    miscompares = 0;

    tbl[0]  = '{2'd1, 32'h10,  32'h12344321, 32'h0,        1'b0};
    tbl[1]  = '{2'd0, 32'h10,  32'h0,        32'h12344321, 1'b0};
    tbl[2]  = '{2'd1, 32'h04,  32'hDEADBEEF, 32'h12344321, 1'b0};
    tbl[3]  = '{2'd0, 32'h04,  32'h0,        32'hDEADBEEF, 1'b0};
    tbl[4]  = '{2'd0, 32'h13,  32'h0,        32'h0,        1'b1};
    tbl[5]  = '{2'd0, 32'h10,  32'h0,        32'h12344321, 1'b0};
    tbl[6]  = '{2'd1, 32'h100, 32'h8,        32'h12344321, 1'b0};
    tbl[7]  = '{2'd0, 32'h000, 32'h0,        32'h8,        1'b0};
    tbl[8]  = '{2'd2, 32'h08,  32'h55AA55AA, 32'h8,        1'b0};
    tbl[9]  = '{2'd0, 32'h08,  32'h0,        32'h55AA55AA, 1'b0};
    tbl[10] = '{2'd1, 32'h13,  32'h11111111, 32'h55AA55AA, 1'b1};
    tbl[11] = '{2'd0, 32'h10,  32'h0,        32'h12344321, 1'b0};
    tbl[12] = '{2'd1, 32'h20,  32'h0BADF00D, 32'h12344321, 1'b0};

    reset     = 1'b1;
    memread   = 1'b0;
    memwrite  = 1'b0;
    addr      = 32'd0;
    writedata = 32'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_readdata", readdata, 32'd0);
    chk("rst_misalign", 32'(misalign), 32'd0);
    chk("rst_stall_noreq", 32'(stall), 32'd0);
    memread = 1'b1;
    #1;
    chk("rst_stall_req", 32'(stall), 32'd1);
    memread = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;

    // entries run back to back: each request in the IDLE after DONE
    for (int i = 0; i < 13; i++)
      access(tbl[i].op, tbl[i].a, tbl[i].d, tbl[i].rd, tbl[i].mis);

    // abort a store mid-flight with async reset
    memwrite  = 1'b1;
    addr      = 32'h20;
    writedata = 32'hCAFEF00D;
    @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    chk("abort_readdata", readdata, 32'd0);
    chk("abort_stall_req", 32'(stall), 32'd1);
    memwrite = 1'b0;
    #1;
    chk("abort_stall_noreq", 32'(stall), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    access(2'd0, 32'h20, 32'h0, 32'h0BADF00D, 1'b0);
    idle_gap();

    rd_m = 32'h0BADF00D;
    for (int i = 0; i < 2**DL; i++) begin
      d = $urandom;
      access(2'd1, 32'(i * 4), d, rd_m, 1'b0);
      mem_m[i] = d;
    end

    for (int n = 0; n < 300; n++) begin
      op = 2'($urandom_range(2));
      a  = $urandom;
      d  = $urandom;
      if ($urandom_range(3) != 0) a[1:0] = 2'd0;
      em = (a[1:0] != 2'd0);
      if (op == 2'd0) begin
        rd_m = em ? 32'd0 : mem_m[a[DL+1:2]];
      end else if (!em) begin
        mem_m[a[DL+1:2]] = d;
      end
      er = rd_m;
      access(op, a, d, er, em);
      if ($urandom_range(4) == 0) idle_gap();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
